ocp_config_initiator: RTL
=========================

# ocp_config_initiator

OCP master for the NI configuration port. It turns single-word read/write requests from a local requester, such as a boot-time config loader or a debug bridge, into OCP transactions toward the config bus responder. It tracks the command handshake (SCmdAccept) and the response handshake (SResp/MRespAccept), then returns read data or an error to the requester. One transaction is outstanding at a time, and a watchdog bounds every phase.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255. Cycle budget per phase (command, then response). 0 disables the watchdog. Range 0..65535.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a clk edge.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  32  word address, passed unchanged to MAddr.
- req_wdata  in  32  write data.
- req_byteen  in  4  byte enables, used for writes only.
- resp_valid  out  1  one-cycle pulse; the transaction is complete.
- resp_rdata  out  32  read data; 0 for writes and errors.
- resp_error  out  1  SResp was ERR/FAIL, or the watchdog expired.
- resp_timeout  out  1  the watchdog expired (implies resp_error).
- ocp_config_m_MCmd  out  3  000 IDLE, 001 WR, 010 RD.
- ocp_config_m_MAddr  out  32
- ocp_config_m_MData  out  32
- ocp_config_m_MByteEn  out  4
- ocp_config_m_MRespAccept  out  1
- ocp_config_s_SResp  in  2  00 NULL, 01 DVA, 10 FAIL, 11 ERR.
- ocp_config_s_SData  in  32
- ocp_config_s_SCmdAccept  in  1

## Operation
- FSM states: IDLE, CMD, RESP, DONE. The watchdog counter is 16 bits wide.
- IDLE:
  - req_ready=1.
  - On handshake: register MCmd (WR if req_wr, else RD), MAddr=req_addr.
  - For a write: MData=req_wdata, MByteEn=req_byteen. For a read: MData=0, MByteEn=1111.
  - Clear the counter and go to CMD.
- CMD:
  - MCmd, MAddr, MData and MByteEn hold stable.
  - If SCmdAccept=1 at the edge: MCmd←IDLE, MAddr/MData/MByteEn←0, counter←0, go to RESP.
  - Otherwise the counter increments. When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without accept: MCmd←IDLE, latch error+timeout, go to DONE.
- RESP:
  - MRespAccept=1, decoded from the state register.
  - If SResp≠00 at the edge:
    - Latch resp_rdata=SData when SResp=01 and the transaction is a read; otherwise 0.
    - Latch resp_error=(SResp≠01).
    - Go to DONE.
  - Otherwise the counter increments. On expiry (same rule as CMD): latch error+timeout, go to DONE.
- DONE:
  - resp_valid=1 for exactly this one cycle, then go to IDLE.
  - resp_rdata/resp_error/resp_timeout hold their values until the next DONE.
- There is no backpressure on the response. The requester must sample it during the resp_valid cycle.
- A late SResp arriving after a timeout while the FSM is in IDLE is ignored; MRespAccept=0 there.

## Timing
- Reset, asynchronous, active-low:
  - State=IDLE.
  - MCmd=000, MAddr=0, MData=0, MByteEn=0, MRespAccept=0.
  - req_ready=1 (combinational from state; 0 while reset is asserted is also permitted).
  - resp_valid=0, resp_rdata=0, resp_error=0, resp_timeout=0, counter=0.
- Reset asserted mid-transaction aborts it immediately. No resp_valid is produced and MCmd returns to IDLE in the same instant.
- All OCP master outputs are registered except MRespAccept. MRespAccept is a decode of the state register only, with no combinational path from SResp.
- Minimum latency, with a responder that accepts in the command cycle and answers with a registered response:
  - Handshake at edge 0.
  - MCmd valid in cycle 1; SCmdAccept sampled at edge 1.
  - SResp=DVA in cycle 2, sampled at edge 2.
  - resp_valid in cycle 3.
  - Next request accepted at edge 4 (req_ready is high in cycle 4).
  - Throughput is therefore 1 transaction per 4 cycles.
- SResp seen during CMD is ignored, since the responder must not answer before accept. A response equal to DVA in the same edge as the transition into RESP is not possible.
- Watchdog boundary: with TIMEOUT_CYCLES=N, the phase aborts at the Nth consecutive cycle without progress. N=1 aborts if the first cycle does not progress.

## Test plan
- Write with immediate accept: req addr=0x0000_2004, wdata=0xDEAD_BEEF, byteen=1111 -> cycle 1 MCmd=001, MAddr=0x2004, MData=0xDEADBEEF; cycle 2 MRespAccept=1; SResp=01 -> cycle 3 resp_valid=1, error=0, rdata=0.
- Read with back-to-back requests: read 0x0800, SData=0x1234_5678 with DVA -> resp_rdata=0x12345678; a second request held valid is accepted exactly 4 cycles after the first.
- Delayed accept: SCmdAccept held low for 5 cycles -> MCmd/MAddr/MData stable for all 6 cycles; the response follows normally.
- ERR response: a write answered with SResp=11 -> resp_error=1, resp_timeout=0, rdata=0.
- Watchdog, with TIMEOUT_CYCLES=8:
  - No accept -> MCmd returns to 000 after 8 cycles in CMD, then resp_valid with error=1, timeout=1.
  - Repeat with accept but no SResp -> same outcome from RESP.
  - A late DVA arriving afterward produces no resp_valid.
- Reset mid-RESP: assert reset during RESP -> all outputs return to reset values asynchronously with no resp_valid; after release a new read completes normally.

Source files
------------

// File: rtl/ocp_config_initiator.sv
// OCP master for the NI configuration port: one outstanding single-word read or
// write, command and response handshakes, and a per-phase watchdog.
module ocp_config_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byteen,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        resp_timeout,
  output logic [2:0]  ocp_config_m_MCmd,
  output logic [31:0] ocp_config_m_MAddr,
  output logic [31:0] ocp_config_m_MData,
  output logic [3:0]  ocp_config_m_MByteEn,
  output logic        ocp_config_m_MRespAccept,
  input  logic [1:0]  ocp_config_s_SResp,
  input  logic [31:0] ocp_config_s_SData,
  input  logic        ocp_config_s_SCmdAccept
);

  localparam logic [2:0]  MCMD_IDLE = 3'b000;
  localparam logic [2:0]  MCMD_WR   = 3'b001;
  localparam logic [2:0]  MCMD_RD   = 3'b010;
  localparam logic [1:0]  SRESP_NULL = 2'b00;
  localparam logic [1:0]  SRESP_DVA  = 2'b01;
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RESP, ST_DONE} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_is_read;
  logic [2:0]  r_mcmd;
  logic [31:0] r_maddr;
  logic [31:0] r_mdata;
  logic [3:0]  r_mbyteen;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_error;
  logic        r_resp_timeout;
  logic        w_expired;

  // The counter holds the number of stalled cycles already spent in the phase,
  // so the abort fires on the edge that ends the Nth stalled cycle.
  assign w_expired = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_is_read      <= 1'b0;
      r_mcmd         <= MCMD_IDLE;
      r_maddr        <= '0;
      r_mdata        <= '0;
      r_mbyteen      <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= '0;
      r_resp_error   <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_is_read <= !req_wr;
            r_mcmd    <= req_wr ? MCMD_WR : MCMD_RD;
            r_maddr   <= req_addr;
            r_mdata   <= req_wr ? req_wdata : 32'h0;
            r_mbyteen <= req_wr ? req_byteen : 4'b1111;
            r_cnt     <= '0;
            r_state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (ocp_config_s_SCmdAccept) begin
            r_mcmd    <= MCMD_IDLE;
            r_maddr   <= '0;
            r_mdata   <= '0;
            r_mbyteen <= '0;
            r_cnt     <= '0;
            r_state   <= ST_RESP;
          end else if (w_expired) begin
            r_mcmd         <= MCMD_IDLE;
            r_maddr        <= '0;
            r_mdata        <= '0;
            r_mbyteen      <= '0;
            r_resp_rdata   <= '0;
            r_resp_error   <= 1'b1;
            r_resp_timeout <= 1'b1;
            r_resp_valid   <= 1'b1;
            r_state        <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          if (ocp_config_s_SResp != SRESP_NULL) begin
            r_resp_rdata   <= (ocp_config_s_SResp == SRESP_DVA && r_is_read)
                              ? ocp_config_s_SData : 32'h0;
            r_resp_error   <= (ocp_config_s_SResp != SRESP_DVA);
            r_resp_timeout <= 1'b0;
            r_resp_valid   <= 1'b1;
            r_state        <= ST_DONE;
          end else if (w_expired) begin
            r_resp_rdata   <= '0;
            r_resp_error   <= 1'b1;
            r_resp_timeout <= 1'b1;
            r_resp_valid   <= 1'b1;
            r_state        <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // MRespAccept is a pure state decode so SResp never reaches it combinationally.
  assign ocp_config_m_MRespAccept = (r_state == ST_RESP);
  assign req_ready                = (r_state == ST_IDLE);

  assign ocp_config_m_MCmd    = r_mcmd;
  assign ocp_config_m_MAddr   = r_maddr;
  assign ocp_config_m_MData   = r_mdata;
  assign ocp_config_m_MByteEn = r_mbyteen;
  assign resp_valid           = r_resp_valid;
  assign resp_rdata           = r_resp_rdata;
  assign resp_error           = r_resp_error;
  assign resp_timeout         = r_resp_timeout;

endmodule
